// File: rtl/cache.sv
// Direct-mapped read-only instruction cache, 64-bit lines, 16-bit words.
// Ports: inp_clk, inp_rst (async high), inp_address[15:0] byte address,
//   inp_lineData[63:0] line holding inp_address, out_instruction[15:0],
//   out_hit (combinational). A miss fills the whole line on the next edge.
module cache #(
  parameter int LINES   = 8,
  parameter int INDEX_W = $clog2(LINES),
  parameter int TAG_W   = 16 - 3 - INDEX_W
) (
  input  logic        inp_clk,
  input  logic        inp_rst,
  input  logic [15:0] inp_address,
  input  logic [63:0] inp_lineData,
  output logic [15:0] out_instruction,
  output logic        out_hit
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [63:0]      data_mem [LINES];

  logic [1:0]         word_off;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   addr_tag;
  logic               fill;

  // Bit 0 is the byte offset; fetches are halfword aligned.
  logic unused_byte_off;
  assign unused_byte_off = inp_address[0];

  assign word_off = inp_address[2:1];
  assign idx      = inp_address[2+INDEX_W:3];
  assign addr_tag = inp_address[15:3+INDEX_W];

  assign out_hit = valid[idx] && (tag_mem[idx] == addr_tag);

  always_comb begin
    out_instruction = 16'h0000;
    if (out_hit)
      out_instruction = data_mem[idx][16*word_off +: 16];
  end

  // Fill only on a miss; a fill edge during reset is dropped.
  assign fill = !out_hit && !inp_rst;

  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst)
      valid <= '0;
    else if (fill)
      valid[idx] <= 1'b1;
  end

  // Tags and data need no reset: valid bits gate every use.
  always_ff @(posedge inp_clk) begin
    if (fill) begin
      tag_mem[idx]  <= addr_tag;
      data_mem[idx] <= inp_lineData;
    end
  end

endmodule

// File: tb/tb_cache.sv
// Directed vector bench for the instruction cache.
// Table of vectors plus a hand-written async reset sequence.
module tb_cache;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [63:0] line;
  logic [15:0] instr;
  logic        hit;

  int checks;
  int failures;

  cache dut (
    .inp_clk        (clk),
    .inp_rst        (rst),
    .inp_address    (addr),
    .inp_lineData   (line),
    .out_instruction(instr),
    .out_hit        (hit)
  );

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic [63:0] line;
    logic        tick;
    logic        exp_hit;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] L0 = 64'hFFFF_FFF0_FF00_F000;
  localparam logic [63:0] L1 = 64'h1111_1110_1100_1000;
  localparam logic [63:0] L2 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] L7 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] LN = 64'h5555_6666_7777_8888;

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    #1;
  endtask

  task automatic check(input string name,
                       input logic exp_hit,
                       input logic [15:0] exp_instr);
    checks++;
    if (hit !== exp_hit || instr !== exp_instr) begin
      failures++;
      $display("FAIL %s: hit=%b instr=%h, want hit=%b instr=%h",
               name, hit, instr, exp_hit, exp_instr);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    addr = 16'h0000;
    line = L0;
    checks = 0;
    failures = 0;

    // rst addr line tick hit instr
    vecs.push_back('{1'b1, 16'h0000, L0, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{1'b1, 16'h0000, L0, 1'b1, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 16'h0000, L0, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 16'h0000, L0, 1'b1, 1'b1, 16'hF000});
    vecs.push_back('{1'b0, 16'h0002, 64'h0, 1'b1, 1'b1, 16'hFF00});
    vecs.push_back('{1'b0, 16'h0004, 64'h0, 1'b0, 1'b1, 16'hFFF0});
    vecs.push_back('{1'b0, 16'h0006, 64'h0, 1'b0, 1'b1, 16'hFFFF});
    vecs.push_back('{1'b0, 16'h0003, 64'h0, 1'b0, 1'b1, 16'hFF00});
    vecs.push_back('{1'b0, 16'h0008, L1, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 16'h0008, L1, 1'b1, 1'b1, 16'h1000});
    vecs.push_back('{1'b0, 16'h000A, L1, 1'b0, 1'b1, 16'h1100});
    vecs.push_back('{1'b0, 16'h000C, L1, 1'b0, 1'b1, 16'h1110});
    vecs.push_back('{1'b0, 16'h000E, L1, 1'b0, 1'b1, 16'h1111});
    vecs.push_back('{1'b0, 16'h0000, L1, 1'b0, 1'b1, 16'hF000});
    vecs.push_back('{1'b0, 16'h0040, L2, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 16'h0040, L2, 1'b1, 1'b1, 16'hDDDD});
    vecs.push_back('{1'b0, 16'h0046, L2, 1'b0, 1'b1, 16'hAAAA});
    vecs.push_back('{1'b0, 16'h0000, L0, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 16'hFFFE, L7, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 16'hFFFE, L7, 1'b1, 1'b1, 16'h1234});
    vecs.push_back('{1'b0, 16'hFFF8, L7, 1'b0, 1'b1, 16'hDEF0});
    vecs.push_back('{1'b0, 16'h000A, L7, 1'b0, 1'b1, 16'h1100});
    vecs.push_back('{1'b0, 16'h0044, L0, 1'b0, 1'b1, 16'hBBBB});

    #3;
    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      addr = vecs[i].addr;
      line = vecs[i].line;
      #1;
      if (vecs[i].tick)
        tick();
      check($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_instr);
    end

    // Async reset mid-run, between edges, with lines 0, 1, 7 valid.
    addr = 16'h0008;
    line = L1;
    #1;
    check("pre_rst_hit", 1'b1, 16'h1000);
    #2 rst = 1'b1;
    #1;
    check("rst_async_drop", 1'b0, 16'h0000);
    addr = 16'h0040;
    #1;
    check("rst_line0", 1'b0, 16'h0000);
    addr = 16'hFFFE;
    line = L7;
    #1;
    tick();
    check("rst_fill_suppressed", 1'b0, 16'h0000);
    rst = 1'b0;
    #1;
    check("post_rst_ffe", 1'b0, 16'h0000);
    addr = 16'h0008;
    #1;
    check("post_rst_008", 1'b0, 16'h0000);
    addr = 16'h0040;
    #1;
    check("post_rst_040", 1'b0, 16'h0000);
    addr = 16'h000C;
    line = LN;
    #1;
    tick();
    check("refill_new_data", 1'b1, 16'h6666);
    addr = 16'h0008;
    #1;
    check("refill_word0", 1'b1, 16'h8888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache.md
Name: cache

Overview:
- Direct-mapped, read-only instruction cache in the RISC core fetch path.
- Takes a 16-bit byte address and returns one 16-bit instruction, with a combinational hit flag.
- On a miss, it fills the whole 64-bit line from the line-data bus at the next clock edge.
- The memory side always presents, on inp_lineData, the 64-bit line containing the current inp_address.

Parameters:
- LINES, 8, number of cache lines; power of two, ≥2.
- INDEX_W, log2(LINES) = 3, index field width.
- TAG_W, 16-3-INDEX_W = 10, tag field width.

Ports:
- inp_clk  in  1  clock; all state updates on rising edge.
- inp_rst  in  1  reset; asynchronous, active-high.
- inp_address  in  16  byte address of the requested instruction.
- inp_lineData  in  64  line fill data for the line containing inp_address.
- out_instruction  out  16  fetched instruction.
- out_hit  out  1  1 = requested instruction is valid in the cache.

Behaviour:
- Address split:
  - bit[0] is the byte offset and is ignored (instructions are halfword aligned).
  - bits[2:1] are the word offset (0..3).
  - bits[2+INDEX_W:3] are the index.
  - bits[15:3+INDEX_W] are the tag.
- Line word order is little-endian: offset 0 = lineData[15:0], 1 = [31:16], 2 = [47:32], 3 = [63:48].
- Storage per line: valid bit, TAG_W tag, 64-bit data.
- out_hit is combinational: valid[index] && tag[index] == address tag.
- out_instruction is combinational:
  - Hit: the selected word of the stored line.
  - Miss: 16'h0000.
- Miss fill: on the rising edge where out_hit = 0 and reset is low, line[index] gets data = inp_lineData, tag = address tag, valid = 1.
  - out_hit rises right after that edge, with no further wait.
  - Miss-to-hit latency is one clock edge.
- On a hit, no state changes; inp_lineData is ignored, even if it differs from the stored data.
- A miss to an index holding a different tag evicts the old line unconditionally. There is no write-back because the cache is read-only.
- Address changes between edges are legal. Hit and instruction follow the address combinationally; only the value present at the rising edge decides whether a fill happens.
- Reset (asynchronous, immediate):
  - All valid bits are cleared; tags and data may be left unchanged.
  - out_hit = 0 and out_instruction = 0 while reset is asserted, and afterwards until a fill.
  - Reset asserted mid-operation discards all lines. A fill edge coinciding with reset is suppressed.
- Simultaneous events cannot arise: there is a single read port, and a fill only occurs on a miss.
- No X propagation is allowed: out_instruction stays 0 whenever out_hit is 0, including before any fill.

Test Plan:
- Reset, then cold miss: assert inp_rst, release; address 0x0000, lineData 0xFFFF_FFF0_FF00_F000.
  - Before the edge: hit = 0, instr = 0x0000.
  - After one rising edge: hit = 1, instr = 0xF000.
- Same-line hits: after that fill, addresses 0x0002, 0x0004, 0x0006 -> hit = 1 immediately, instr = 0xFF00, 0xFFF0, 0xFFFF. No refill occurs, even if lineData changes.
- Next line: address 0x0008, lineData 0x1111_1110_1100_1000.
  - Miss, then after one edge hit = 1, instr = 0x1000.
  - Address 0x000A -> 0x1100; address 0x000C -> 0x1110.
  - Address 0x0000 still hits with 0xF000.
- Conflict eviction: with 0x0000 cached, access 0x0040 (same index 0, tag 1) with lineData 0xAAAA_BBBB_CCCC_DDDD.
  - Miss, fill, then instr = 0xDDDD.
  - Address 0x0000 now misses with instr = 0.
- Odd byte address: 0x0003 after the line-0 fill -> same result as 0x0002 (0xFF00).
- Async reset mid-run: with several lines valid, pulse inp_rst between clock edges.
  - hit drops to 0 immediately, instr = 0.
  - Every previously cached address misses until refilled.
